// File: rtl/switch_handshake_host_pkg.sv
// Shared types for the host side of the picoMIPS switch handshake.
// The state enum and the data size are also used by the decoder bench.
package switch_handshake_host_pkg;

    localparam int HS_DATA_SIZE = 8;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_SETUP,
        HS_HIGH,
        HS_LOW,
        HS_ERROR
    } hs_state_t;

    // The timer must hold both the setup load and the hold-wait load.
    function automatic int hs_timer_width(input int setup_cycles, input int timeout_cycles);
        int max_val;
        max_val = (setup_cycles > timeout_cycles) ? setup_cycles : timeout_cycles;
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/switch_handshake_host_hs_timer.sv
// Loadable down-counter. It is done while the count sits at zero.
// The same counter serves the setup hold and the HIGH/LOW ack waits.
module hs_timer #(
    parameter int CNT = 8
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic           load,
    input  logic [CNT-1:0] load_val,
    input  logic           en,
    output logic           done
);

    localparam logic [CNT-1:0] ONE = 1;

    logic [CNT-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/switch_handshake_host.sv
// Host-side driver for the picoMIPS WLD1/WLD0 handshake. It presents each accepted word on sw_data,
// runs sw8 through a 0-1-0 cycle, and moves on only after the processor acks each phase.
module switch_handshake_host
    import switch_handshake_host_pkg::*;
#(
    parameter int DATA_W         = HS_DATA_SIZE,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] sw_data,
    output logic              sw8,
    input  logic              ack,
    input  logic              err_clr,
    output logic              busy,
    output logic              timeout,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int TW = hs_timer_width(SETUP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES);
    // The wait count is loaded one below the limit, so zero lands on the last allowed cycle.
    localparam logic [TW-1:0] HOLD_LOAD  = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_INC = 1;

    hs_state_t         state_reg;
    logic [DATA_W-1:0] sw_data_reg;
    logic              sw8_reg;
    logic              in_ready_reg;
    logic              busy_reg;
    logic              timeout_reg;
    logic [CNT_W-1:0]  words_sent_reg;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;
    logic          hold_expired;
    logic          accept;

    assign accept       = in_valid && in_ready_reg;
    assign hold_expired = (TIMEOUT_CYCLES != 0) && timer_done;

    // Reload the timer on every entry into SETUP, HIGH and LOW.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = HOLD_LOAD;
        case (state_reg)
            HS_IDLE: begin
                if (accept) begin
                    timer_load = 1'b1;
                    timer_val  = SETUP_LOAD;
                end
            end
            HS_SETUP: timer_load = timer_done;
            HS_HIGH:  timer_load = ack;
            default:  timer_load = 1'b0;
        endcase
    end

    hs_timer #(
        .CNT(TW)
    ) u_timer (
        .clk      (clk),
        .nReset   (nReset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (1'b1),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_reg      <= HS_IDLE;
            sw_data_reg    <= '0;
            sw8_reg        <= 1'b0;
            in_ready_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            words_sent_reg <= '0;
        end else begin
            case (state_reg)
                HS_IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        sw_data_reg  <= in_data;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= HS_SETUP;
                    end
                end
                HS_SETUP: begin
                    if (timer_done) begin
                        sw8_reg   <= 1'b1;
                        state_reg <= HS_HIGH;
                    end
                end
                HS_HIGH: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (ack) begin
                        sw8_reg   <= 1'b0;
                        state_reg <= HS_LOW;
                    end else if (hold_expired) begin
                        sw8_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= HS_ERROR;
                    end
                end
                HS_LOW: begin
                    if (ack) begin
                        words_sent_reg <= words_sent_reg + WORD_INC;
                        in_ready_reg   <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= HS_IDLE;
                    end else if (hold_expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= HS_ERROR;
                    end
                end
                HS_ERROR: begin
                    if (err_clr) begin
                        timeout_reg  <= 1'b0;
                        sw_data_reg  <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= HS_IDLE;
                    end
                end
                default: state_reg <= HS_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign sw_data    = sw_data_reg;
    assign sw8        = sw8_reg;
    assign busy       = busy_reg;
    assign timeout    = timeout_reg;
    assign words_sent = words_sent_reg;

endmodule

// File: tb/tb_switch_handshake_host.sv
// Scoreboard bench for switch_handshake_host: words are queued on acceptance and
// checked against sw_data when sw8 rises; the completion count is modelled in the bench.
module tb_switch_handshake_host;
    import switch_handshake_host_pkg::*;

    localparam int DATA_W         = HS_DATA_SIZE;
    localparam int SETUP_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CNT_W          = 2;

    logic              clk = 1'b0;
    logic              nReset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sw_data;
    logic              sw8;
    logic              ack;
    logic              err_clr;
    logic              busy;
    logic              timeout;
    logic [CNT_W-1:0]  words_sent;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_words = '0;

    switch_handshake_host #(
        .DATA_W         (DATA_W),
        .SETUP_CYCLES   (SETUP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sw_data    (sw_data),
        .sw8        (sw8),
        .ack        (ack),
        .err_clr    (err_clr),
        .busy       (busy),
        .timeout    (timeout),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    // A word is expected on sw_data once the valid/ready handshake completes.
    always @(posedge clk) begin
        if (nReset && in_valid && in_ready) exp_q.push_back(in_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] data, output bit ok);
        bit rdy;
        int n;
        ok = 1'b0;
        n  = 0;
        in_data  = data;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            rdy = in_ready;
            tick();
            n++;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_sw8(input logic level, input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (sw8 !== level && cycles < budget) begin
            tick();
            cycles++;
        end
        ok = (sw8 === level);
    endtask

    task automatic test_reset();
        nReset = 1'b0; in_valid = 1'b0; in_data = '0; ack = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        total_cnt++; if (sw8 !== 1'b0) $display("FAIL reset_sw8: got %0b expected 0", sw8); else pass_cnt++;
        total_cnt++; if (sw_data !== '0) $display("FAIL reset_sw_data: got %0h expected 0", sw_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %0b expected 0", timeout); else pass_cnt++;
        total_cnt++; if (words_sent !== '0) $display("FAIL reset_words: got %0d expected 0", words_sent); else pass_cnt++;
        nReset = 1'b1;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b expected 1", in_ready); else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_single_word();
        bit ok;
        int cyc;
        logic [DATA_W-1:0] exp_d;
        send_word(8'hA5, ok);
        total_cnt++; if (!ok) $display("FAIL single_accept: got not accepted expected accepted"); else pass_cnt++;
        total_cnt++; if (sw_data !== 8'hA5) $display("FAIL single_sw_data: got %0h expected a5", sw_data); else pass_cnt++;
        wait_sw8(1'b1, 20, cyc, ok);
        total_cnt++; if (!ok || cyc != SETUP_CYCLES + 1) $display("FAIL single_latency: got %0d cycles expected %0d", cyc, SETUP_CYCLES + 1); else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL single_sb: got empty queue expected one word");
        else begin
            exp_d = exp_q.pop_front();
            if (sw_data !== exp_d) $display("FAIL single_sb: got %0h expected %0h", sw_data, exp_d); else pass_cnt++;
        end
        pulse_ack();
        total_cnt++; if (sw8 !== 1'b0) $display("FAIL single_low_sw8: got %0b expected 0", sw8); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_low_busy: got %0b expected 1", busy); else pass_cnt++;
        pulse_ack();
        exp_words++;
        total_cnt++; if (words_sent !== exp_words) $display("FAIL single_words: got %0d expected %0d", words_sent, exp_words); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL single_idle: got busy=%0b ready=%0b expected busy=0 ready=1", busy, in_ready); else pass_cnt++;
        $display("word a5 sent, words_sent=%0d", words_sent);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        logic [DATA_W-1:0] exp_d;
        send_word(8'h01, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_accept1: got not accepted expected accepted"); else pass_cnt++;
        in_data  = 8'h02;
        in_valid = 1'b1;
        wait_sw8(1'b1, 20, cyc, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_rise1: got no sw8 rise expected rise"); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_busy: got %0b expected 0", in_ready); else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 1) $display("FAIL b2b_sb1: got %0d queued expected 1", exp_q.size());
        else begin
            exp_d = exp_q.pop_front();
            if (sw_data !== exp_d || exp_d !== 8'h01) $display("FAIL b2b_sb1: got %0h expected 01", sw_data); else pass_cnt++;
        end
        tick();
        pulse_ack();
        tick();
        pulse_ack();
        exp_words++;
        $display("word 01 sent, words_sent=%0d", words_sent);
        wait_sw8(1'b1, 20, cyc, ok);
        in_valid = 1'b0;
        total_cnt++; if (!ok) $display("FAIL b2b_rise2: got no sw8 rise expected rise"); else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 1) $display("FAIL b2b_sb2: got %0d queued expected 1", exp_q.size());
        else begin
            exp_d = exp_q.pop_front();
            if (sw_data !== exp_d || exp_d !== 8'h02) $display("FAIL b2b_sb2: got %0h expected 02", sw_data); else pass_cnt++;
        end
        tick();
        pulse_ack();
        tick();
        pulse_ack();
        exp_words++;
        total_cnt++; if (words_sent !== exp_words) $display("FAIL b2b_words: got %0d expected %0d", words_sent, exp_words); else pass_cnt++;
        $display("word 02 sent, words_sent=%0d", words_sent);
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        logic [DATA_W-1:0] exp_d;
        send_word(8'h3C, ok);
        wait_sw8(1'b1, 20, cyc, ok);
        total_cnt++;
        if (!ok || exp_q.size() == 0) $display("FAIL to_rise: got rise=%0b queued=%0d expected rise=1 queued=1", ok, exp_q.size());
        else begin
            exp_d = exp_q.pop_front();
            if (sw_data !== exp_d) $display("FAIL to_sb: got %0h expected %0h", sw_data, exp_d); else pass_cnt++;
        end
        repeat (TIMEOUT_CYCLES - 1) tick();
        total_cnt++; if (sw8 !== 1'b1 || timeout !== 1'b0) $display("FAIL to_early: got sw8=%0b timeout=%0b expected sw8=1 timeout=0", sw8, timeout); else pass_cnt++;
        tick();
        total_cnt++; if (timeout !== 1'b1) $display("FAIL to_fire: got %0b expected 1", timeout); else pass_cnt++;
        total_cnt++; if (sw8 !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL to_error_outs: got sw8=%0b ready=%0b busy=%0b expected 0 0 1", sw8, in_ready, busy); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (timeout !== 1'b1 || words_sent !== exp_words) $display("FAIL to_ack_ignored: got timeout=%0b words=%0d expected 1 %0d", timeout, words_sent, exp_words); else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total_cnt++; if (timeout !== 1'b0 || busy !== 1'b0 || sw_data !== '0) $display("FAIL to_clear: got timeout=%0b busy=%0b sw_data=%0h expected 0 0 0", timeout, busy, sw_data); else pass_cnt++;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL to_ready: got %0b expected 1", in_ready); else pass_cnt++;
        $display("word 3c timed out and cleared, words_sent=%0d", words_sent);
    endtask

    task automatic test_stray_ack();
        bit ok;
        int cyc;
        logic [DATA_W-1:0] exp_d;
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        exp_words = '0;
        exp_q.delete();
        tick();
        pulse_ack();
        total_cnt++; if (busy !== 1'b0 || words_sent !== '0 || in_ready !== 1'b1) $display("FAIL stray_idle: got busy=%0b words=%0d ready=%0b expected 0 0 1", busy, words_sent, in_ready); else pass_cnt++;
        send_word(8'h5A, ok);
        pulse_ack();
        total_cnt++; if (sw8 !== 1'b0 || busy !== 1'b1) $display("FAIL stray_setup: got sw8=%0b busy=%0b expected 0 1", sw8, busy); else pass_cnt++;
        wait_sw8(1'b1, 20, cyc, ok);
        total_cnt++; if (!ok || cyc != SETUP_CYCLES) $display("FAIL stray_setup_latency: got %0d cycles expected %0d", cyc, SETUP_CYCLES); else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL stray_sb: got empty queue expected one word");
        else begin
            exp_d = exp_q.pop_front();
            if (sw_data !== exp_d) $display("FAIL stray_sb: got %0h expected %0h", sw_data, exp_d); else pass_cnt++;
        end
        repeat (TIMEOUT_CYCLES - 1) tick();
        pulse_ack();
        total_cnt++; if (timeout !== 1'b0 || sw8 !== 1'b0 || busy !== 1'b1) $display("FAIL stray_last_cycle_ack: got timeout=%0b sw8=%0b busy=%0b expected 0 0 1", timeout, sw8, busy); else pass_cnt++;
        pulse_ack();
        exp_words++;
        total_cnt++; if (words_sent !== exp_words) $display("FAIL stray_words: got %0d expected %0d", words_sent, exp_words); else pass_cnt++;
        $display("word 5a sent, words_sent=%0d", words_sent);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        send_word(8'hC3, ok);
        wait_sw8(1'b1, 20, cyc, ok);
        total_cnt++; if (!ok) $display("FAIL rmid_rise: got no sw8 rise expected rise"); else pass_cnt++;
        exp_q.delete();
        nReset = 1'b0;
        tick();
        total_cnt++; if (sw8 !== 1'b0 || sw_data !== '0 || busy !== 1'b0) $display("FAIL rmid_outs: got sw8=%0b sw_data=%0h busy=%0b expected 0 0 0", sw8, sw_data, busy); else pass_cnt++;
        total_cnt++; if (words_sent !== '0 || timeout !== 1'b0) $display("FAIL rmid_words: got words=%0d timeout=%0b expected 0 0", words_sent, timeout); else pass_cnt++;
        nReset = 1'b1;
        exp_words = '0;
        tick();
        $display("word c3 dropped by reset");
    endtask

    task automatic test_wrap();
        bit ok;
        int cyc;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            d = DATA_W'($urandom_range(0, 255));
            send_word(d, ok);
            wait_sw8(1'b1, 20, cyc, ok);
            total_cnt++;
            if (!ok || exp_q.size() == 0) $display("FAIL wrap_rise: got rise=%0b queued=%0d expected 1 1", ok, exp_q.size());
            else begin
                exp_d = exp_q.pop_front();
                if (sw_data !== exp_d) $display("FAIL wrap_sb: got %0h expected %0h", sw_data, exp_d); else pass_cnt++;
            end
            pulse_ack();
            pulse_ack();
            exp_words++;
            total_cnt++; if (words_sent !== exp_words) $display("FAIL wrap_words: got %0d expected %0d", words_sent, exp_words); else pass_cnt++;
            $display("word %02h sent, words_sent=%0d", d, words_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_timeout();
        test_stray_ack();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
